intersection_phase_scheduler: RTL
=================================

Name: intersection_phase_scheduler

Overview:
- Single-clock scheduler that shares right-of-way ("green") among NUM_APPR intersection approaches. Uses round-robin arbitration, min/max green timing, yellow and all-red clearance, and latched pedestrian requests with walk/wait indication.
- Replaces per-direction independent FSMs with one central arbiter, so at most one approach is ever non-red.
- All timing derives from an internal 1 s tick enable; there is no divided clock.

Parameters:
- CLK_FREQ, 50000000, clk cycles per 1 s tick.
- NUM_APPR, 4, number of approaches (2..8); index 0 = North, then clockwise.
- MIN_GREEN, 5, minimum green in seconds.
- MAX_GREEN, 10, maximum green in seconds when other requests are pending. Constraint: MAX_GREEN >= MIN_GREEN.
- YELLOW_T, 3, yellow duration in seconds (>=1).
- ALLRED_T, 1, all-red clearance in seconds (>=1).
- WALK_T, 4, walk duration in seconds. Constraint: WALK_T <= MIN_GREEN.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- veh_req  in  NUM_APPR  level vehicle-presence per approach.
- ped_req  in  NUM_APPR  pedestrian button per approach; a pulse of any length latches.
- red  out  NUM_APPR  red lamp per approach.
- yellow  out  NUM_APPR  yellow lamp per approach.
- green  out  NUM_APPR  green lamp per approach.
- ped_walk  out  NUM_APPR  walk lamp per approach.
- ped_wait  out  NUM_APPR  blinking wait lamp per approach.
- cur_appr  out  $clog2(NUM_APPR)  approach currently owning right-of-way.

Behaviour:
- Tick: prescaler counts 0..CLK_FREQ-1 and asserts tick for 1 cycle at the terminal count.
  - sec_cnt (width $clog2(MAX_GREEN+1), saturating) increments on tick and is cleared on every phase change.
  - blink toggles on each tick.
- Phases: GREEN, YELLOW, ALLRED. Transitions are evaluated only on tick cycles.
- other_req = OR over i != cur of (veh_req[i] | ped_pend[i]).
- GREEN -> YELLOW on tick when other_req AND either condition holds:
  - (sec_cnt+1) >= MAX_GREEN, or
  - (sec_cnt+1) >= MIN_GREEN AND !veh_req[cur] AND walk not active.
- Rest in green: with no other_req, GREEN persists indefinitely and sec_cnt saturates.
- YELLOW -> ALLRED when (sec_cnt+1) == YELLOW_T.
- ALLRED -> GREEN when (sec_cnt+1) == ALLRED_T. On this transition:
  - cur becomes the first index after cur (circular) with veh_req | ped_pend set.
  - If none is requesting, cur is unchanged.
- Pedestrian latch:
  - ped_pend[i] is set by ped_req[i]=1 on any cycle.
  - ped_pend[i] is cleared on the cycle a walk for approach i starts.
  - Set and clear on the same cycle: set wins, so the request is served next cycle round.
- Walk start: on entry to GREEN with ped_pend[cur]=1, ped_walk[cur]=1 for exactly WALK_T ticks, then 0.
- Late request: ped_req[cur] during GREEN after entry stays pending and is served on the next grant of cur.
- Lamps:
  - Exactly one of red/yellow/green is set per approach.
  - Non-cur approaches are always red.
  - During ALLRED all approaches are red.
  - ped_walk is set only while cur is in GREEN.
- ped_wait[i] = ped_pend[i] & blink.
- All outputs are registered and change 1 cycle after the phase/state update.
- Reset values:
  - cur=0, phase GREEN, sec_cnt=0, prescaler=0, blink=0, ped_pend=0.
  - green=0001 (bit 0 only), red = all bits except bit 0, yellow=0, ped_walk=0, ped_wait=0, cur_appr=0.
- Reset asserted mid-phase aborts immediately to the reset state on the next clock edge.

Optional Feature:
- Macro EMERGENCY_PREEMPT_EN.
- With the macro defined:
  - Adds input preempt [NUM_APPR].
  - If any preempt bit is set and cur is not the lowest set index p, a GREEN phase exits to YELLOW on the next tick regardless of MIN_GREEN or walk. An active walk is cut and its ped_pend is not re-set.
  - The following ALLRED grants p.
  - GREEN at p holds while preempt[p]=1; normal rules resume after it drops.
- Without the macro: no preempt port; behaviour exactly as above.

Decomposition:
- Shared package traffic_pkg:
  - phase_t enum {PH_GREEN, PH_YELLOW, PH_ALLRED}.
  - Lamp-index constants.
  - Function rr_next(req, cur) returning the next circular requester.
- Sub-module tick_gen (CLK_FREQ): prescaler producing the 1-cycle tick.

Test Plan (CLK_FREQ=4, defaults otherwise):
- Reset, no requests: green=0001 held 100 ticks; red=1110; no yellow ever.
- veh_req=0010 from reset, veh_req[0]=0: GREEN exits after 5 ticks; yellow[0] for 3 ticks; all-red 1 tick; then green=0010, cur_appr=1.
- veh_req=0011 held: approach 0 stays green exactly 10 ticks (MAX_GREEN), then yellow; next grant is 1, then back to 0.
- 1-cycle ped_req[2] while cur=0: ped_wait[2] blinks at 1 tick per toggle. Grant order skips to 2; ped_walk[2]=1 for 4 ticks; ped_pend[2] clears at walk start; green lasts >= 5 ticks.
- ped_req[0] at sec_cnt=3 of green 0, veh_req=0100: no walk now; 0 -> 2 -> 0; walk[0] asserts on re-entry.
- EMERGENCY_PREEMPT_EN, preempt=1000 at sec_cnt=1 of green 0: yellow on next tick, all-red, green=1000 held until preempt drops; rst mid-yellow returns green=0001 next cycle.

Source files
------------

// File: rtl/intersection_phase_scheduler_pkg.sv
// Shared types and helpers for the intersection phase scheduler:
// phase encoding, lamp selection and round-robin grant search.
package traffic_pkg;

  typedef enum logic [1:0] {
    PH_GREEN,
    PH_YELLOW,
    PH_ALLRED
  } phase_t;

  localparam int LAMP_RED    = 0;
  localparam int LAMP_YELLOW = 1;
  localparam int LAMP_GREEN  = 2;

  localparam int MAX_APPR = 8;

  // Only the approach holding right-of-way ever shows anything but red.
  function automatic int lamp_sel(input phase_t ph, input logic is_cur);
    int sel;
    sel = LAMP_RED;
    if (is_cur) begin
      if (ph == PH_GREEN)       sel = LAMP_GREEN;
      else if (ph == PH_YELLOW) sel = LAMP_YELLOW;
    end
    return sel;
  endfunction

  function automatic logic [2:0] rr_next(input logic [MAX_APPR-1:0] req,
                                         input logic [2:0] cur,
                                         input int n);
    logic [2:0] res;
    logic       found;
    int         idx;
    res   = cur;
    found = 1'b0;
    idx   = 0;
    for (int k = 1; k <= MAX_APPR; k++) begin
      if (k <= n) begin
        idx = (int'(cur) + k) % n;
        if (!found && req[idx[2:0]]) begin
          res   = idx[2:0];
          found = 1'b1;
        end
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/intersection_phase_scheduler_tick_gen.sv
// Prescaler producing a one-cycle tick enable every CLK_FREQ clocks
// (the 1 s timebase of the scheduler).
module tick_gen #(
  parameter int CLK_FREQ = 50000000
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int CW = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    tick  = (cnt_q == CW'(CLK_FREQ - 1));
    cnt_d = tick ? '0 : cnt_q + CW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/intersection_phase_scheduler.sv
// Central round-robin traffic phase scheduler with min/max green, yellow,
// all-red clearance and latched pedestrian walk. Optional: EMERGENCY_PREEMPT_EN.
module intersection_phase_scheduler
  import traffic_pkg::*;
#(
  parameter int CLK_FREQ  = 50000000,
  parameter int NUM_APPR  = 4,
  parameter int MIN_GREEN = 5,
  parameter int MAX_GREEN = 10,
  parameter int YELLOW_T  = 3,
  parameter int ALLRED_T  = 1,
  parameter int WALK_T    = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_APPR-1:0]         veh_req,
  input  logic [NUM_APPR-1:0]         ped_req,
`ifdef EMERGENCY_PREEMPT_EN
  input  logic [NUM_APPR-1:0]         preempt,
`endif
  output logic [NUM_APPR-1:0]         red,
  output logic [NUM_APPR-1:0]         yellow,
  output logic [NUM_APPR-1:0]         green,
  output logic [NUM_APPR-1:0]         ped_walk,
  output logic [NUM_APPR-1:0]         ped_wait,
  output logic [$clog2(NUM_APPR)-1:0] cur_appr
);

  localparam int CAW = $clog2(NUM_APPR);
  localparam int SW  = $clog2(MAX_GREEN + 1);
  localparam int WW  = (WALK_T > 0) ? $clog2(WALK_T + 1) : 1;

  logic tick;

  tick_gen #(.CLK_FREQ(CLK_FREQ)) u_tick_gen (
    .clk (clk),
    .rst (rst),
    .tick(tick)
  );

  phase_t              phase_q, phase_d;
  logic [CAW-1:0]      cur_q, cur_d, grant;
  logic [SW-1:0]       sec_cnt_q, sec_cnt_d, sec_sat;
  logic [SW:0]         sec_inc;
  logic [WW-1:0]       walk_cnt_q, walk_cnt_d;
  logic                blink_q, blink_d;
  logic [NUM_APPR-1:0] ped_pend_q, ped_pend_d, ped_clr;
  logic [NUM_APPR-1:0] req_all, cur_onehot;
  logic                other_req, walk_active, normal_exit, exit_green;

  logic [NUM_APPR-1:0] red_q, red_d, yellow_q, yellow_d, green_q, green_d;
  logic [NUM_APPR-1:0] ped_walk_q, ped_walk_d, ped_wait_q, ped_wait_d;
  logic [CAW-1:0]      cur_appr_q, cur_appr_d;

`ifdef EMERGENCY_PREEMPT_EN
  logic                pre_any;
  logic [CAW-1:0]      pre_idx;
`endif

  always_comb begin
    req_all     = veh_req | ped_pend_q;
    cur_onehot  = NUM_APPR'(1) << cur_q;
    other_req   = |(req_all & ~cur_onehot);
    walk_active = (walk_cnt_q != '0);
    sec_inc     = {1'b0, sec_cnt_q} + (SW+1)'(1);
    sec_sat     = sec_inc[SW] ? sec_cnt_q : sec_inc[SW-1:0];
    normal_exit = other_req &&
                  ((sec_inc >= (SW+1)'(MAX_GREEN)) ||
                   ((sec_inc >= (SW+1)'(MIN_GREEN)) && !veh_req[cur_q] && !walk_active));
    grant       = CAW'(rr_next(MAX_APPR'(req_all), 3'(cur_q), NUM_APPR));
`ifdef EMERGENCY_PREEMPT_EN
    // Lowest-index preempting approach wins; holding it suspends normal exit rules.
    pre_any = |preempt;
    pre_idx = '0;
    for (int i = NUM_APPR - 1; i >= 0; i--) begin
      if (preempt[i]) pre_idx = CAW'(i);
    end
    exit_green = pre_any ? (cur_q != pre_idx) : normal_exit;
    if (pre_any) grant = pre_idx;
`else
    exit_green = normal_exit;
`endif
  end

  always_comb begin
    phase_d    = phase_q;
    cur_d      = cur_q;
    sec_cnt_d  = sec_cnt_q;
    walk_cnt_d = walk_cnt_q;
    blink_d    = blink_q;
    ped_clr    = '0;
    if (tick) begin
      blink_d   = ~blink_q;
      sec_cnt_d = sec_sat;
      if (walk_active) walk_cnt_d = walk_cnt_q - WW'(1);
      case (phase_q)
        PH_GREEN: begin
          if (exit_green) begin
            phase_d    = PH_YELLOW;
            sec_cnt_d  = '0;
            walk_cnt_d = '0;
          end
        end
        PH_YELLOW: begin
          if (sec_inc == (SW+1)'(YELLOW_T)) begin
            phase_d   = PH_ALLRED;
            sec_cnt_d = '0;
          end
        end
        PH_ALLRED: begin
          if (sec_inc == (SW+1)'(ALLRED_T)) begin
            phase_d   = PH_GREEN;
            sec_cnt_d = '0;
            cur_d     = grant;
            if (ped_pend_q[grant]) begin
              walk_cnt_d     = WW'(WALK_T);
              ped_clr[grant] = 1'b1;
            end
          end
        end
        default: phase_d = PH_GREEN;
      endcase
    end
    // A press landing on the walk-start cycle survives for the next grant.
    ped_pend_d = (ped_pend_q & ~ped_clr) | ped_req;
  end

  always_comb begin
    int sel;
    sel      = LAMP_RED;
    red_d    = '0;
    yellow_d = '0;
    green_d  = '0;
    for (int i = 0; i < NUM_APPR; i++) begin
      sel         = lamp_sel(phase_q, cur_q == CAW'(i));
      red_d[i]    = (sel == LAMP_RED);
      yellow_d[i] = (sel == LAMP_YELLOW);
      green_d[i]  = (sel == LAMP_GREEN);
    end
    ped_walk_d = ((phase_q == PH_GREEN) && walk_active) ? cur_onehot : '0;
    ped_wait_d = ped_pend_q & {NUM_APPR{blink_q}};
    cur_appr_d = cur_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q    <= PH_GREEN;
      cur_q      <= '0;
      sec_cnt_q  <= '0;
      walk_cnt_q <= '0;
      blink_q    <= 1'b0;
      ped_pend_q <= '0;
      red_q      <= ~NUM_APPR'(1);
      yellow_q   <= '0;
      green_q    <= NUM_APPR'(1);
      ped_walk_q <= '0;
      ped_wait_q <= '0;
      cur_appr_q <= '0;
    end else begin
      phase_q    <= phase_d;
      cur_q      <= cur_d;
      sec_cnt_q  <= sec_cnt_d;
      walk_cnt_q <= walk_cnt_d;
      blink_q    <= blink_d;
      ped_pend_q <= ped_pend_d;
      red_q      <= red_d;
      yellow_q   <= yellow_d;
      green_q    <= green_d;
      ped_walk_q <= ped_walk_d;
      ped_wait_q <= ped_wait_d;
      cur_appr_q <= cur_appr_d;
    end
  end

  assign red      = red_q;
  assign yellow   = yellow_q;
  assign green    = green_q;
  assign ped_walk = ped_walk_q;
  assign ped_wait = ped_wait_q;
  assign cur_appr = cur_appr_q;

endmodule
